// File: rtl/lockin_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lockin_pkg
// Shared state encoding and configuration widths for the lock-in sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
package lockin_pkg;

    localparam int STATE_W = 3;
    localparam int CFG_W   = 16;
    localparam int PARAM_W = 32;

    localparam logic [STATE_W-1:0] ENC_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ENC_CHECK    = 3'd1;
    localparam logic [STATE_W-1:0] ENC_RST      = 3'd2;
    localparam logic [STATE_W-1:0] ENC_WAIT_RDY = 3'd3;
    localparam logic [STATE_W-1:0] ENC_RUN      = 3'd4;
    localparam logic [STATE_W-1:0] ENC_DONE     = 3'd5;
    localparam logic [STATE_W-1:0] ENC_ERROR    = 3'd6;

    localparam logic [CFG_W-1:0] MIN_M = 16'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = ENC_IDLE,
        ST_CHECK    = ENC_CHECK,
        ST_RST      = ENC_RST,
        ST_WAIT_RDY = ENC_WAIT_RDY,
        ST_RUN      = ENC_RUN,
        ST_DONE     = ENC_DONE,
        ST_ERROR    = ENC_ERROR
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_watchdog
// Loadable down-counter; a load value of zero leaves it permanently idle.
// Revision: 1.0
// ---------------------------------------------------------------------------
module seq_watchdog #(
    parameter int TMO_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMO_W-1:0] load_value,
    input  logic             run,
    output logic             expired
);

    logic [TMO_W-1:0] r_count;

    // Flags on the last live cycle so the owner leaves its state on the edge the count hits zero.
    assign expired = run && !load && (r_count == TMO_W'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (run && (r_count != '0)) begin
            r_count <= r_count - TMO_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lockin_measurement_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lockin_measurement_sequencer
// Run control for the coherent-average + lock-in chain: config check, chain reset, run, report.
// Revision: 1.0
// ---------------------------------------------------------------------------
module lockin_measurement_sequencer
    import lockin_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter int TMO_W      = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CFG_W-1:0]   cfg_m,
    input  logic [CFG_W-1:0]   cfg_n_ma,
    input  logic [CFG_W-1:0]   cfg_n_ca,
    input  logic [CNT_W-1:0]   cfg_n_results,
    input  logic [TMO_W-1:0]   cfg_timeout,
    output logic               chain_reset_n,
    output logic               chain_enable,
    output logic [PARAM_W-1:0] param_m,
    output logic [PARAM_W-1:0] param_n_ma,
    output logic [PARAM_W-1:0] param_n_ca,
    input  logic               chain_ready,
    input  logic               chain_finished,
    input  logic               result_valid,
    output logic               busy,
    output logic               done,
    output logic               err_cfg,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   result_count,
    output logic               irq,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int                 c_RST_W    = $clog2(RST_CYCLES + 1);
    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RST_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [c_RST_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0]   r_n_results;
    logic [TMO_W-1:0]   r_timeout;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_abort;
    logic               w_cfg_bad;
    logic               w_rst_last;
    logic               w_count_en;
    logic               w_count_hit;
    logic               w_wd_load;
    logic               w_wd_run;
    logic               w_wd_expired;

    assign w_abort     = abort && (r_state != ST_IDLE);
    assign w_cfg_bad   = (param_m < PARAM_W'(MIN_M)) || (param_n_ma == '0) ||
                         (param_n_ca == '0) || (r_n_results == '0);
    assign w_rst_last  = (r_rst_cnt == c_RST_LAST);
    assign w_count_inc = result_count + CNT_W'(1);
    assign w_count_en  = (r_state == ST_RUN) && result_valid && !w_abort &&
                         (result_count < r_n_results);
    assign w_count_hit = (r_state == ST_RUN) && result_valid && (w_count_inc >= r_n_results);

    // Reload on entry to WAIT_RDY / RUN and on every result; an abort makes the load moot.
    assign w_wd_load = ((r_state == ST_RST) && w_rst_last) ||
                       ((r_state == ST_WAIT_RDY) && chain_ready) ||
                       ((r_state == ST_RUN) && result_valid);
    assign w_wd_run  = (r_state == ST_WAIT_RDY) || (r_state == ST_RUN);

    seq_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_wd_load),
        .load_value (r_timeout),
        .run        (w_wd_run),
        .expired    (w_wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_next = ST_CHECK;
            ST_CHECK:    w_next = w_cfg_bad ? ST_ERROR : ST_RST;
            ST_RST:      if (w_rst_last) w_next = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (chain_ready)       w_next = ST_RUN;
                else if (w_wd_expired) w_next = ST_ERROR;
            end
            ST_RUN: begin
                if (w_count_hit || chain_finished) w_next = ST_DONE;
                else if (w_wd_expired)             w_next = ST_ERROR;
            end
            ST_DONE:     if (start) w_next = ST_CHECK;
            ST_ERROR:    if (start) w_next = ST_CHECK;
            default:     w_next = ST_IDLE;
        endcase
        if (w_abort) w_next = ST_IDLE;
    end

    // Outputs are registered from the next state so they line up with state_dbg.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rst_cnt     <= '0;
            r_n_results   <= '0;
            r_timeout     <= '0;
            param_m       <= '0;
            param_n_ma    <= '0;
            param_n_ca    <= '0;
            chain_reset_n <= 1'b0;
            chain_enable  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cfg       <= 1'b0;
            err_timeout   <= 1'b0;
            result_count  <= '0;
            irq           <= 1'b0;
        end else begin
            r_rst_cnt     <= (r_state == ST_RST) ? r_rst_cnt + c_RST_W'(1) : '0;
            chain_reset_n <= (w_next != ST_IDLE) && (w_next != ST_RST) && (w_next != ST_ERROR);
            chain_enable  <= (w_next == ST_RUN);
            busy          <= (w_next == ST_CHECK) || (w_next == ST_RST) ||
                             (w_next == ST_WAIT_RDY) || (w_next == ST_RUN);
            done          <= (w_next == ST_DONE);
            irq           <= ((w_next == ST_DONE) && (r_state != ST_DONE)) ||
                             ((w_next == ST_ERROR) && (r_state != ST_ERROR));

            if (w_next == ST_CHECK) begin
                param_m      <= PARAM_W'(cfg_m);
                param_n_ma   <= PARAM_W'(cfg_n_ma);
                param_n_ca   <= PARAM_W'(cfg_n_ca);
                r_n_results  <= cfg_n_results;
                r_timeout    <= cfg_timeout;
                err_cfg      <= 1'b0;
                err_timeout  <= 1'b0;
                result_count <= '0;
            end else begin
                if ((r_state == ST_CHECK) && (w_next == ST_ERROR)) err_cfg <= 1'b1;
                if (w_wd_run && (w_next == ST_ERROR))              err_timeout <= 1'b1;
                if (w_count_en)                                    result_count <= w_count_inc;
            end
        end
    end

    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lockin_measurement_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lockin_measurement_sequencer
// Directed scenario bench for the lock-in run-control sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_lockin_measurement_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_m = 16'd8;
    logic [15:0] cfg_n_ma = 16'd4;
    logic [15:0] cfg_n_ca = 16'd2;
    logic [15:0] cfg_n_results = 16'd3;
    logic [31:0] cfg_timeout = 32'd0;
    logic        chain_reset_n;
    logic        chain_enable;
    logic [31:0] param_m;
    logic [31:0] param_n_ma;
    logic [31:0] param_n_ca;
    logic        chain_ready = 1'b0;
    logic        chain_finished = 1'b0;
    logic        result_valid = 1'b0;
    logic        busy;
    logic        done;
    logic        err_cfg;
    logic        err_timeout;
    logic [15:0] result_count;
    logic        irq;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int irq_seen = 0;
    int en_seen  = 0;

    lockin_measurement_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .cfg_m          (cfg_m),
        .cfg_n_ma       (cfg_n_ma),
        .cfg_n_ca       (cfg_n_ca),
        .cfg_n_results  (cfg_n_results),
        .cfg_timeout    (cfg_timeout),
        .chain_reset_n  (chain_reset_n),
        .chain_enable   (chain_enable),
        .param_m        (param_m),
        .param_n_ma     (param_n_ma),
        .param_n_ca     (param_n_ca),
        .chain_ready    (chain_ready),
        .chain_finished (chain_finished),
        .result_valid   (result_valid),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg),
        .err_timeout    (err_timeout),
        .result_count   (result_count),
        .irq            (irq),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (irq) irq_seen++;
        if (chain_enable) en_seen++;
    endtask

    task automatic go_to_run(input logic [15:0] nres, input logic [31:0] tmo);
        cfg_m = 16'd8; cfg_n_ma = 16'd4; cfg_n_ca = 16'd2;
        cfg_n_results = nres; cfg_timeout = tmo;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (state_dbg == 3'd3) break;
            tick();
        end
        n_checks++; if (state_dbg !== 3'd3) $display("FAIL reach_wait_rdy state=%0d want 3", state_dbg); else n_pass++;
        chain_ready = 1'b1; tick(); chain_ready = 1'b0;
        n_checks++; if (state_dbg !== 3'd4) $display("FAIL reach_run state=%0d want 4", state_dbg); else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick(); tick();
        n_checks++; if ({state_dbg, chain_reset_n, chain_enable, busy, done, irq} !== 8'b000_00000)
            $display("FAIL reset_ctrl got st=%0d crn=%b en=%b busy=%b done=%b irq=%b want all 0",
                     state_dbg, chain_reset_n, chain_enable, busy, done, irq); else n_pass++;
        n_checks++; if ({param_m, param_n_ma, param_n_ca, result_count, err_cfg, err_timeout} !== '0)
            $display("FAIL reset_data got m=%0d nma=%0d nca=%0d cnt=%0d ec=%b et=%b want 0",
                     param_m, param_n_ma, param_n_ca, result_count, err_cfg, err_timeout); else n_pass++;
        reset_n = 1'b1;
        tick();
        n_checks++; if ({state_dbg, chain_reset_n} !== 4'b000_0)
            $display("FAIL idle_hold got st=%0d crn=%b want 0/0", state_dbg, chain_reset_n); else n_pass++;
    endtask

    task automatic test_nominal();
        int s;
        int low;
        irq_seen = 0;
        cfg_m = 16'd8; cfg_n_ma = 16'd4; cfg_n_ca = 16'd2; cfg_n_results = 16'd3; cfg_timeout = 32'd100;
        s = cyc;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if ({state_dbg, busy, chain_reset_n} !== 5'b001_1_1)
            $display("FAIL nom_check got st=%0d busy=%b crn=%b want 1/1/1", state_dbg, busy, chain_reset_n); else n_pass++;
        n_checks++; if ({param_m, param_n_ma, param_n_ca} !== {32'd8, 32'd4, 32'd2})
            $display("FAIL nom_params got %0d/%0d/%0d want 8/4/2", param_m, param_n_ma, param_n_ca); else n_pass++;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state_dbg == 3'd3) break;
            if (!chain_reset_n) low++;
        end
        n_checks++; if (low !== 4) $display("FAIL nom_rst_len got %0d want 4", low); else n_pass++;
        n_checks++; if ({state_dbg, chain_reset_n, chain_enable} !== 5'b011_1_0)
            $display("FAIL nom_wait got st=%0d crn=%b en=%b want 3/1/0", state_dbg, chain_reset_n, chain_enable); else n_pass++;
        tick(); tick(); tick(); tick();
        chain_ready = 1'b1; tick(); chain_ready = 1'b0;
        n_checks++; if ({state_dbg, chain_enable} !== 4'b100_1)
            $display("FAIL nom_run got st=%0d en=%b want 4/1", state_dbg, chain_enable); else n_pass++;
        n_checks++; if (cyc - s !== 11) $display("FAIL nom_latency got %0d want 11", cyc - s); else n_pass++;
        result_valid = 1'b1; tick(); result_valid = 1'b0; tick();
        result_valid = 1'b1; tick(); result_valid = 1'b0; tick();
        n_checks++; if ({state_dbg, result_count} !== {3'd4, 16'd2})
            $display("FAIL nom_mid got st=%0d cnt=%0d want 4/2", state_dbg, result_count); else n_pass++;
        result_valid = 1'b1; tick(); result_valid = 1'b0;
        n_checks++; if ({state_dbg, result_count, done, irq, chain_enable, chain_reset_n} !== {3'd5, 16'd3, 4'b1101})
            $display("FAIL nom_done got st=%0d cnt=%0d done=%b irq=%b en=%b crn=%b want 5/3/1/1/0/1",
                     state_dbg, result_count, done, irq, chain_enable, chain_reset_n); else n_pass++;
        tick(); tick();
        n_checks++; if ({irq, done} !== 2'b01 || irq_seen !== 1)
            $display("FAIL nom_irq_once got irq=%b done=%b seen=%0d want 0/1/1", irq, done, irq_seen); else n_pass++;
    endtask

    task automatic test_cfg_error();
        irq_seen = 0; en_seen = 0;
        cfg_m = 16'd1; cfg_n_ma = 16'd4; cfg_n_ca = 16'd2; cfg_n_results = 16'd3; cfg_timeout = 32'd0;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if ({state_dbg, done} !== 4'b001_0)
            $display("FAIL cfg_check got st=%0d done=%b want 1/0", state_dbg, done); else n_pass++;
        tick();
        n_checks++; if ({state_dbg, err_cfg, irq, chain_enable, chain_reset_n, busy} !== 8'b110_1_1_0_0_0)
            $display("FAIL cfg_error got st=%0d ec=%b irq=%b en=%b crn=%b busy=%b want 6/1/1/0/0/0",
                     state_dbg, err_cfg, irq, chain_enable, chain_reset_n, busy); else n_pass++;
        tick(); tick();
        n_checks++; if (irq_seen !== 1 || en_seen !== 0 || err_cfg !== 1'b1)
            $display("FAIL cfg_once got irq_seen=%0d en_seen=%0d ec=%b want 1/0/1", irq_seen, en_seen, err_cfg); else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        cfg_m = 16'd8; cfg_n_results = 16'd3; cfg_timeout = 32'd20;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (err_cfg !== 1'b0) $display("FAIL tmo_clear_cfg got %b want 0", err_cfg); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (state_dbg == 3'd3) break;
            tick();
        end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick(); n++;
            if (state_dbg != 3'd3) break;
        end
        n_checks++; if (n !== 20 || state_dbg !== 3'd6)
            $display("FAIL tmo_len got %0d cycles st=%0d want 20/6", n, state_dbg); else n_pass++;
        n_checks++; if ({err_timeout, err_cfg, irq} !== 3'b101)
            $display("FAIL tmo_flags got et=%b ec=%b irq=%b want 1/0/1", err_timeout, err_cfg, irq); else n_pass++;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (err_timeout !== 1'b0) $display("FAIL tmo_clear got %b want 0", err_timeout); else n_pass++;
        tick(); tick(); tick(); tick(); tick(); tick(); tick();
    endtask

    task automatic test_abort();
        go_to_run(16'd3, 32'd0);
        result_valid = 1'b1; tick(); result_valid = 1'b0;
        n_checks++; if (result_count !== 16'd1) $display("FAIL abort_pre got %0d want 1", result_count); else n_pass++;
        irq_seen = 0;
        abort = 1'b1; result_valid = 1'b1; tick(); abort = 1'b0; result_valid = 1'b0;
        n_checks++; if ({state_dbg, result_count, chain_enable, chain_reset_n, busy, irq} !== {3'd0, 16'd1, 4'b0000})
            $display("FAIL abort_run got st=%0d cnt=%0d en=%b crn=%b busy=%b irq=%b want 0/1/0/0/0/0",
                     state_dbg, result_count, chain_enable, chain_reset_n, busy, irq); else n_pass++;
        abort = 1'b1; tick(); abort = 1'b0; tick();
        n_checks++; if (state_dbg !== 3'd0 || irq_seen !== 0)
            $display("FAIL abort_idle got st=%0d irq_seen=%0d want 0/0", state_dbg, irq_seen); else n_pass++;
    endtask

    task automatic test_finished();
        go_to_run(16'd5, 32'd0);
        result_valid = 1'b1; tick(); result_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if ({state_dbg, result_count} !== {3'd4, 16'd1})
            $display("FAIL fin_start_ignored got st=%0d cnt=%0d want 4/1", state_dbg, result_count); else n_pass++;
        result_valid = 1'b1; chain_finished = 1'b1; tick(); result_valid = 1'b0; chain_finished = 1'b0;
        n_checks++; if ({state_dbg, result_count, done, irq} !== {3'd5, 16'd2, 2'b11})
            $display("FAIL fin_done got st=%0d cnt=%0d done=%b irq=%b want 5/2/1/1",
                     state_dbg, result_count, done, irq); else n_pass++;
    endtask

    task automatic test_reset_in_run();
        go_to_run(16'd5, 32'd0);
        result_valid = 1'b1; tick(); result_valid = 1'b0;
        reset_n = 1'b0; tick();
        n_checks++; if ({state_dbg, chain_reset_n, chain_enable, busy, done, irq, err_cfg, err_timeout} !== 10'd0)
            $display("FAIL rst_run_ctrl got st=%0d crn=%b en=%b busy=%b done=%b irq=%b want all 0",
                     state_dbg, chain_reset_n, chain_enable, busy, done, irq); else n_pass++;
        n_checks++; if ({param_m, param_n_ma, param_n_ca, result_count} !== '0)
            $display("FAIL rst_run_data got m=%0d nma=%0d nca=%0d cnt=%0d want 0",
                     param_m, param_n_ma, param_n_ca, result_count); else n_pass++;
        reset_n = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_cfg_error();
        test_timeout();
        test_abort();
        test_finished();
        test_reset_in_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout bench did not complete within 200000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
